// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky FAULT state.
// Latency: 3 cycles (branch), 4 (ALU/U/J/store), 5 (load) with zero-wait memories; +1 per wait cycle.
// Backpressure: holds imem/dmem requests until acked; a bounded wait counter forces FAULT on expiry.
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 16,
    parameter bit SUPPORT_UJ   = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] Op_i,
    input  logic       imem_ack_i,
    input  logic       dmem_ack_i,
    input  logic       branch_taken_i,
    output logic       imem_req_o,
    output logic       dmem_rd_o,
    output logic       dmem_wr_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_src_o,
    output logic [1:0] ALUOp_o,
    output logic [1:0] ALUSrcA_o,
    output logic       ALUSrc_o,
    output logic [2:0] immSelect_o,
    output logic       RegWrite_o,
    output logic [1:0] MemToReg_o,
    output logic       illegal_o,
    output logic       timeout_o,
    output logic [2:0] state_o
);

    localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [6:0]    op_q;
    logic [CW-1:0] wait_cnt;
    logic          illegal_q, timeout_q;
    logic          set_illegal, set_timeout;
    logic          legal, wait_hit;

    // Opcode legality, evaluated on the live IR output during DECODE.
    always_comb begin
        legal = 1'b0;
        case (Op_i)
            OP_I, OP_R, OP_B, OP_LD, OP_ST:          legal = 1'b1;
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:       legal = SUPPORT_UJ;
            default:                                 legal = 1'b0;
        endcase
    end

    assign wait_hit = (MEM_WAIT_MAX != 0) && (wait_cnt == CW'(MEM_WAIT_MAX));

    // Next-state and datapath control; everything is forced low while reset is held.
    always_comb begin
        state_nxt   = state;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        imem_req_o  = 1'b0;
        dmem_rd_o   = 1'b0;
        dmem_wr_o   = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_src_o    = 2'd0;
        ALUOp_o     = 2'b00;
        ALUSrcA_o   = 2'd0;
        ALUSrc_o    = 1'b0;
        immSelect_o = 3'd0;
        RegWrite_o  = 1'b0;
        MemToReg_o  = 2'd0;
        illegal_o   = illegal_q;
        timeout_o   = timeout_q;
        state_o     = state;

        // ALU operand/immediate selects are set in EXEC and held through MEM and WB.
        // U-type and JALR need the immediate on the B operand, so ALUSrc is set for them too.
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            case (op_q)
                OP_R:     ALUOp_o = 2'b10;
                OP_I:     begin ALUOp_o = 2'b11; ALUSrc_o = 1'b1; end
                OP_LD:    ALUSrc_o = 1'b1;
                OP_ST:    begin ALUSrc_o = 1'b1; immSelect_o = 3'd1; end
                OP_B:     begin ALUOp_o = 2'b01; immSelect_o = 3'd2; end
                OP_LUI:   begin ALUSrcA_o = 2'd2; ALUSrc_o = 1'b1; immSelect_o = 3'd3; end
                OP_AUIPC: begin ALUSrcA_o = 2'd1; ALUSrc_o = 1'b1; immSelect_o = 3'd3; end
                OP_JAL:   immSelect_o = 3'd4;
                OP_JALR:  ALUSrc_o = 1'b1;
                default:  ;
            endcase
        end

        case (state)
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_we_o   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wait_hit) begin
                    set_timeout = 1'b1;
                    state_nxt   = S_FAULT;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_nxt = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_nxt   = S_FAULT;
                end
            end
            S_EXEC: begin
                if (op_q == OP_B) begin
                    pc_we_o   = 1'b1;
                    pc_src_o  = branch_taken_i ? 2'd1 : 2'd0;
                    state_nxt = S_FETCH;
                end else if (op_q == OP_LD || op_q == OP_ST) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                dmem_rd_o = (op_q == OP_LD);
                dmem_wr_o = (op_q != OP_LD);
                if (dmem_ack_i) begin
                    if (op_q == OP_LD) begin
                        state_nxt = S_WB;
                    end else begin
                        pc_we_o   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (wait_hit) begin
                    set_timeout = 1'b1;
                    state_nxt   = S_FAULT;
                end
            end
            S_WB: begin
                RegWrite_o = 1'b1;
                pc_we_o    = 1'b1;
                case (op_q)
                    OP_LD:   MemToReg_o = 2'd1;
                    OP_JAL:  begin MemToReg_o = 2'd2; pc_src_o = 2'd2; end
                    OP_JALR: begin MemToReg_o = 2'd2; pc_src_o = 2'd3; end
                    default: ;
                endcase
                state_nxt = S_FETCH;
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FETCH;
        endcase

        if (rst_i) begin
            imem_req_o  = 1'b0;
            dmem_rd_o   = 1'b0;
            dmem_wr_o   = 1'b0;
            ir_we_o     = 1'b0;
            pc_we_o     = 1'b0;
            pc_src_o    = 2'd0;
            ALUOp_o     = 2'b00;
            ALUSrcA_o   = 2'd0;
            ALUSrc_o    = 1'b0;
            immSelect_o = 3'd0;
            RegWrite_o  = 1'b0;
            MemToReg_o  = 2'd0;
            illegal_o   = 1'b0;
            timeout_o   = 1'b0;
            state_o     = 3'd0;
        end
    end

    // State, latched opcode, saturating wait counter and sticky fault flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_FETCH;
            op_q      <= 7'd0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                op_q <= Op_i;
            end
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if ((state == S_FETCH || state == S_MEM) && wait_cnt != '1) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            illegal_q <= illegal_q | set_illegal;
            timeout_q <= timeout_q | set_timeout;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: table of per-cycle vectors plus hand sequences.
// Three instances: defaults, SUPPORT_UJ=0, and MEM_WAIT_MAX=4; all share the input drivers.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] st;
        logic       ireq;
        logic       drd;
        logic       dwr;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic [1:0] srca;
        logic       srcb;
        logic [2:0] imm;
        logic       rw;
        logic [1:0] m2r;
        logic       ill;
        logic       tmo;
    } outs_t;

    typedef struct {
        logic       r;
        logic [6:0] op;
        logic       ia;
        logic       da;
        logic       br;
        outs_t      e;
    } vec_t;

    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       ia, da, br;
    wire outs_t o0, o1, o2;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multicycle_control #(.MEM_WAIT_MAX(16), .SUPPORT_UJ(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .Op_i(op), .imem_ack_i(ia), .dmem_ack_i(da), .branch_taken_i(br),
        .imem_req_o(o0.ireq), .dmem_rd_o(o0.drd), .dmem_wr_o(o0.dwr), .ir_we_o(o0.irwe),
        .pc_we_o(o0.pcwe), .pc_src_o(o0.pcsrc), .ALUOp_o(o0.aluop), .ALUSrcA_o(o0.srca),
        .ALUSrc_o(o0.srcb), .immSelect_o(o0.imm), .RegWrite_o(o0.rw), .MemToReg_o(o0.m2r),
        .illegal_o(o0.ill), .timeout_o(o0.tmo), .state_o(o0.st));

    multicycle_control #(.MEM_WAIT_MAX(16), .SUPPORT_UJ(1'b0)) dut_nouj (
        .clk_i(clk), .rst_i(rst), .Op_i(op), .imem_ack_i(ia), .dmem_ack_i(da), .branch_taken_i(br),
        .imem_req_o(o1.ireq), .dmem_rd_o(o1.drd), .dmem_wr_o(o1.dwr), .ir_we_o(o1.irwe),
        .pc_we_o(o1.pcwe), .pc_src_o(o1.pcsrc), .ALUOp_o(o1.aluop), .ALUSrcA_o(o1.srca),
        .ALUSrc_o(o1.srcb), .immSelect_o(o1.imm), .RegWrite_o(o1.rw), .MemToReg_o(o1.m2r),
        .illegal_o(o1.ill), .timeout_o(o1.tmo), .state_o(o1.st));

    multicycle_control #(.MEM_WAIT_MAX(4), .SUPPORT_UJ(1'b1)) dut_to (
        .clk_i(clk), .rst_i(rst), .Op_i(op), .imem_ack_i(ia), .dmem_ack_i(da), .branch_taken_i(br),
        .imem_req_o(o2.ireq), .dmem_rd_o(o2.drd), .dmem_wr_o(o2.dwr), .ir_we_o(o2.irwe),
        .pc_we_o(o2.pcwe), .pc_src_o(o2.pcsrc), .ALUOp_o(o2.aluop), .ALUSrcA_o(o2.srca),
        .ALUSrc_o(o2.srcb), .immSelect_o(o2.imm), .RegWrite_o(o2.rw), .MemToReg_o(o2.m2r),
        .illegal_o(o2.ill), .timeout_o(o2.tmo), .state_o(o2.st));

    task automatic row(input logic r, input logic [6:0] opc, input logic a_i, input logic a_d,
                       input logic b, input outs_t e);
        vec_t v;
        v.r = r; v.op = opc; v.ia = a_i; v.da = a_d; v.br = b; v.e = e;
        vecs.push_back(v);
    endtask

    // One cycle: new inputs just after the edge, outputs settle by the falling edge.
    task automatic drive(input logic r, input logic [6:0] opc, input logic a_i, input logic a_d,
                         input logic b);
        @(posedge clk);
        #1;
        rst = r; op = opc; ia = a_i; da = a_d; br = b;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    localparam outs_t Z = '0;

    initial begin
        rst = 1'b1; op = '0; ia = 1'b0; da = 1'b0; br = 1'b0;

        // reset
        row(1, 0, 0, 0, 0, Z);
        // R-type, ALUOp 10 in EXEC, write/PC only in WB
        row(0, 0,     1, 0, 0, '{st:3'd0, ireq:1'b1, irwe:1'b1, default:'0});
        row(0, OP_R,  0, 0, 0, '{st:3'd1, default:'0});
        row(0, 0,     0, 0, 0, '{st:3'd2, aluop:2'b10, default:'0});
        row(0, 0,     0, 0, 0, '{st:3'd4, aluop:2'b10, rw:1'b1, pcwe:1'b1, default:'0});
        // one fetch wait cycle, then load with dmem ack on the 4th MEM cycle
        row(0, 0,     0, 0, 0, '{st:3'd0, ireq:1'b1, default:'0});
        row(0, 0,     1, 0, 0, '{st:3'd0, ireq:1'b1, irwe:1'b1, default:'0});
        row(0, OP_LD, 0, 0, 0, '{st:3'd1, default:'0});
        row(0, 0,     0, 1, 0, '{st:3'd2, srcb:1'b1, default:'0});
        row(0, 0,     0, 0, 0, '{st:3'd3, drd:1'b1, srcb:1'b1, default:'0});
        row(0, 0,     0, 0, 0, '{st:3'd3, drd:1'b1, srcb:1'b1, default:'0});
        row(0, 0,     0, 0, 0, '{st:3'd3, drd:1'b1, srcb:1'b1, default:'0});
        row(0, 0,     0, 1, 0, '{st:3'd3, drd:1'b1, srcb:1'b1, default:'0});
        row(0, 0,     0, 0, 0, '{st:3'd4, srcb:1'b1, rw:1'b1, m2r:2'd1, pcwe:1'b1, default:'0});
        // branch taken, then not taken
        row(0, 0,     1, 0, 0, '{st:3'd0, ireq:1'b1, irwe:1'b1, default:'0});
        row(0, OP_B,  0, 0, 0, '{st:3'd1, default:'0});
        row(0, 0,     0, 0, 1, '{st:3'd2, aluop:2'b01, imm:3'd2, pcwe:1'b1, pcsrc:2'd1, default:'0});
        row(0, 0,     1, 0, 0, '{st:3'd0, ireq:1'b1, irwe:1'b1, default:'0});
        row(0, OP_B,  0, 0, 0, '{st:3'd1, default:'0});
        row(0, 0,     0, 0, 0, '{st:3'd2, aluop:2'b01, imm:3'd2, pcwe:1'b1, default:'0});
        // store, zero wait
        row(0, 0,     1, 0, 0, '{st:3'd0, ireq:1'b1, irwe:1'b1, default:'0});
        row(0, OP_ST, 0, 0, 0, '{st:3'd1, default:'0});
        row(0, 0,     0, 0, 0, '{st:3'd2, srcb:1'b1, imm:3'd1, default:'0});
        row(0, 0,     0, 1, 0, '{st:3'd3, dwr:1'b1, pcwe:1'b1, srcb:1'b1, imm:3'd1, default:'0});
        // JAL
        row(0, 0,      1, 0, 0, '{st:3'd0, ireq:1'b1, irwe:1'b1, default:'0});
        row(0, OP_JAL, 0, 0, 0, '{st:3'd1, default:'0});
        row(0, 0,      0, 0, 0, '{st:3'd2, imm:3'd4, default:'0});
        row(0, 0,      0, 0, 0, '{st:3'd4, imm:3'd4, rw:1'b1, m2r:2'd2, pcwe:1'b1, pcsrc:2'd2, default:'0});
        // JALR
        row(0, 0,       1, 0, 0, '{st:3'd0, ireq:1'b1, irwe:1'b1, default:'0});
        row(0, OP_JALR, 0, 0, 0, '{st:3'd1, default:'0});
        row(0, 0,       0, 0, 0, '{st:3'd2, srcb:1'b1, default:'0});
        row(0, 0,       0, 0, 0, '{st:3'd4, srcb:1'b1, rw:1'b1, m2r:2'd2, pcwe:1'b1, pcsrc:2'd3, default:'0});
        // LUI
        row(0, 0,      1, 0, 0, '{st:3'd0, ireq:1'b1, irwe:1'b1, default:'0});
        row(0, OP_LUI, 0, 0, 0, '{st:3'd1, default:'0});
        row(0, 0,      0, 0, 0, '{st:3'd2, srca:2'd2, srcb:1'b1, imm:3'd3, default:'0});
        row(0, 0,      0, 0, 0, '{st:3'd4, srca:2'd2, srcb:1'b1, imm:3'd3, rw:1'b1, pcwe:1'b1, default:'0});
        // AUIPC
        row(0, 0,        1, 0, 0, '{st:3'd0, ireq:1'b1, irwe:1'b1, default:'0});
        row(0, OP_AUIPC, 0, 0, 0, '{st:3'd1, default:'0});
        row(0, 0,        0, 0, 0, '{st:3'd2, srca:2'd1, srcb:1'b1, imm:3'd3, default:'0});
        row(0, 0,        0, 0, 0, '{st:3'd4, srca:2'd1, srcb:1'b1, imm:3'd3, rw:1'b1, pcwe:1'b1, default:'0});
        // I-type
        row(0, 0,    1, 0, 0, '{st:3'd0, ireq:1'b1, irwe:1'b1, default:'0});
        row(0, OP_I, 0, 0, 0, '{st:3'd1, default:'0});
        row(0, 0,    0, 0, 0, '{st:3'd2, aluop:2'b11, srcb:1'b1, default:'0});
        row(0, 0,    0, 0, 0, '{st:3'd4, aluop:2'b11, srcb:1'b1, rw:1'b1, pcwe:1'b1, default:'0});
        // illegal opcode -> sticky FAULT, acks ignored; reset clears
        row(0, 0,      1, 0, 0, '{st:3'd0, ireq:1'b1, irwe:1'b1, default:'0});
        row(0, OP_BAD, 0, 0, 0, '{st:3'd1, default:'0});
        row(0, 0,      1, 1, 0, '{st:3'd5, ill:1'b1, default:'0});
        row(0, 0,      1, 1, 0, '{st:3'd5, ill:1'b1, default:'0});
        row(1, 0,      1, 0, 0, Z);
        row(0, 0,      1, 0, 0, '{st:3'd0, ireq:1'b1, irwe:1'b1, default:'0});
        // reset during a store MEM wait: write request drops at once, back to FETCH
        row(0, OP_ST,  0, 0, 0, '{st:3'd1, default:'0});
        row(0, 0,      0, 0, 0, '{st:3'd2, srcb:1'b1, imm:3'd1, default:'0});
        row(0, 0,      0, 0, 0, '{st:3'd3, dwr:1'b1, srcb:1'b1, imm:3'd1, default:'0});
        row(1, 0,      0, 0, 0, Z);
        row(0, 0,      0, 0, 0, '{st:3'd0, ireq:1'b1, default:'0});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].op, vecs[i].ia, vecs[i].da, vecs[i].br);
            chk($sformatf("row%0d", i), {9'd0, o0}, {9'd0, vecs[i].e});
        end

        // SUPPORT_UJ=0: JAL is illegal, no further fetch requests
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk("nouj_fetch_irwe", {31'd0, o1.irwe}, 32'd1);
        drive(0, OP_JAL, 0, 0, 0);
        chk("nouj_decode_st", {29'd0, o1.st}, 32'd1);
        drive(0, 0, 1, 0, 0);
        chk("nouj_fault_st", {29'd0, o1.st}, 32'd5);
        chk("nouj_illegal", {31'd0, o1.ill}, 32'd1);
        chk("nouj_ireq_off", {31'd0, o1.ireq}, 32'd0);
        drive(0, 0, 1, 0, 0);
        chk("nouj_fault_hold", {29'd0, o1.st}, 32'd5);

        // MEM_WAIT_MAX=4: fetch ack withheld for 5 cycles -> timeout
        drive(1, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 0, 0);
            if (k == 5) begin
                chk("to_fetch5_st", {29'd0, o2.st}, 32'd0);
                chk("to_fetch5_tmo", {31'd0, o2.tmo}, 32'd0);
                chk("to_fetch5_ireq", {31'd0, o2.ireq}, 32'd1);
            end
        end
        drive(0, 0, 1, 0, 0);
        chk("to_fault_st", {29'd0, o2.st}, 32'd5);
        chk("to_fault_tmo", {31'd0, o2.tmo}, 32'd1);
        chk("to_fault_ireq", {31'd0, o2.ireq}, 32'd0);

        // same, but ack on the 5th fetch cycle wins
        drive(1, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        chk("ack5_irwe", {31'd0, o2.irwe}, 32'd1);
        drive(0, OP_R, 0, 0, 0);
        chk("ack5_decode_st", {29'd0, o2.st}, 32'd1);
        chk("ack5_no_tmo", {31'd0, o2.tmo}, 32'd0);

        // MEM_WAIT_MAX=4: store with dmem ack withheld -> timeout from MEM
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, OP_ST, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) drive(0, 0, 0, 0, 0);
        chk("memwait5_dwr", {31'd0, o2.dwr}, 32'd1);
        drive(0, 0, 0, 1, 0);
        chk("memto_st", {29'd0, o2.st}, 32'd5);
        chk("memto_tmo", {31'd0, o2.tmo}, 32'd1);
        chk("memto_dwr_off", {31'd0, o2.dwr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle RV32I control decoder: a state machine that sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables and multiplexer selects for each step. It adds U/J-type support (LUI, AUIPC, JAL, JALR), which can be disabled by parameter. It also adds request/acknowledge handshakes to instruction and data memory, a wait-state timeout, and a sticky fault state. It sits between the instruction register / ALU compare output and the datapath.

## Interface
- MEM_WAIT_MAX, 16: maximum cycles waiting for a memory ack before a fault is raised; 0 disables the timeout.
- SUPPORT_UJ, 1: 1 decodes LUI/AUIPC/JAL/JALR; 0 treats those opcodes as illegal.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- Op_i  in  7  opcode field from the instruction register.
- imem_ack_i  in  1  instruction memory ack; instruction is valid on Op_i the next cycle.
- dmem_ack_i  in  1  data memory ack (read data valid / write accepted).
- branch_taken_i  in  1  ALU compare result, valid in EXEC.
- imem_req_o  out  1  instruction fetch request.
- dmem_rd_o, dmem_wr_o  out  1 each  data memory read / write request.
- ir_we_o  out  1  instruction register load.
- pc_we_o  out  1  PC load.
- pc_src_o  out  2  next-PC select: 0 = pc+4, 1 = branch target, 2 = jal target, 3 = jalr target (alu result & ~1).
- ALUOp_o  out  2  ALU operation: 00 = add, 01 = branch compare, 10 = R-type funct, 11 = I-type funct.
- ALUSrcA_o  out  2  ALU A operand: 0 = rs1, 1 = pc, 2 = zero.
- ALUSrc_o  out  1  ALU B operand: 0 = rs2, 1 = immediate.
- immSelect_o  out  3  immediate format: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- RegWrite_o  out  1  register file write enable.
- MemToReg_o  out  2  writeback select: 0 = ALU, 1 = memory, 2 = pc+4.
- illegal_o, timeout_o  out  1 each  sticky fault flags.
- state_o  out  3  current state, for debug.

## Operation
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, FAULT = 5. Encodings 6 and 7 fall back to FETCH.
- FETCH:
  - imem_req_o = 1 until imem_ack_i is seen.
  - In the ack cycle: ir_we_o = 1, then go to DECODE.
- DECODE:
  - Latch Op_i into an internal opcode register; all later states use the latched value.
  - Supported opcodes: 0010011, 0110011, 1100011, 0000011, 0100011; with SUPPORT_UJ = 1 also 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL), 1100111 (JALR).
  - Any other opcode: go to FAULT and set illegal_o. Otherwise go to EXEC.
- EXEC, per opcode:
  - R-type: ALUOp = 10, ALUSrc = 0.
  - I-type: ALUOp = 11, ALUSrc = 1, imm = I.
  - Load/store: ALUOp = 00, ALUSrc = 1, imm = I or S respectively.
  - LUI: ALUOp = 00, ALUSrcA = 2, imm = U.
  - AUIPC: ALUOp = 00, ALUSrcA = 1, imm = U.
  - JAL: imm = J.
  - JALR: ALUOp = 00, ALUSrcA = 0, imm = I.
  - Branch: ALUOp = 01, imm = B, pc_we_o = 1, pc_src_o = branch_taken_i ? 1 : 0; go to FETCH.
  - Load/store go to MEM. All others go to WB.
- MEM:
  - Hold dmem_rd_o (load) or dmem_wr_o (store) until dmem_ack_i.
  - On ack, load goes to WB; store asserts pc_we_o with pc_src = 0 and goes to FETCH.
- WB (single cycle):
  - RegWrite_o = 1.
  - MemToReg_o: 1 for load, 2 for JAL/JALR, 0 otherwise.
  - pc_we_o = 1 with pc_src_o = 2 (JAL), 3 (JALR) or 0 (others).
  - Go to FETCH.
- ALU select signals hold their EXEC values through MEM and WB.
- Wait counter:
  - Cleared on entry to FETCH or MEM; increments each cycle without an ack.
  - When the counter equals MEM_WAIT_MAX and there is no ack (MEM_WAIT_MAX ≠ 0): go to FAULT and set timeout_o.
  - The counter saturates; it needs at least clog2(MEM_WAIT_MAX+1) bits.
- FAULT:
  - Terminal until reset: all request, enable and write outputs are 0.
  - illegal_o / timeout_o hold their values.
- Unused select outputs are 0 in every state.

## Timing
- While rst_i = 1 in a cycle: every output is 0, state_o = 0.
- Reset effects: the next state is FETCH; the opcode register, counter and fault flags clear.
- The first cycle after rst_i drops: imem_req_o = 1.
- Outputs are combinational from the state register and the latched opcode.
- branch_taken_i, imem_ack_i and dmem_ack_i feed same-cycle outputs and next-state logic.
- An ack in the same cycle as the request counts; minimum one cycle per wait state.
- Zero-wait-memory cycles per instruction: branch 3, R/I/LUI/AUIPC/JAL/JALR 4, store 4, load 5. Each wait cycle adds one.
- Ack in the cycle the counter reaches MEM_WAIT_MAX: the ack wins and there is no fault.
- Reset asserted mid-instruction (including during MEM with a request outstanding): the request drops the same cycle and there is no writeback.
- Acks arriving outside FETCH/MEM are ignored.

## Test plan
- Reset, then an R-type 0110011 with immediate acks:
  - state_o sequence 0, 1, 2, 4, 0.
  - RegWrite_o = 1 and pc_we_o = 1 only in cycle 4.
  - ALUOp_o = 10 in EXEC.
- Load 0000011 with dmem_ack_i delayed 3 cycles:
  - dmem_rd_o high for 4 cycles.
  - WB has MemToReg_o = 1; total 8 cycles.
- Branch 1100011, branch_taken_i = 1 then 0:
  - EXEC gives pc_we_o = 1 with pc_src_o = 1, then 0.
  - RegWrite_o never asserts; each instruction takes 3 cycles.
- JAL 1101111 with SUPPORT_UJ = 1: WB has MemToReg_o = 2, pc_src_o = 2. With SUPPORT_UJ = 0: FAULT after DECODE, illegal_o = 1, imem_req_o = 0 thereafter.
- MEM_WAIT_MAX = 4 with imem_ack_i withheld: timeout_o = 1 and state_o = 5 after the 5th FETCH cycle. A repeat run with the ack on the 5th cycle must give no fault.
- rst_i pulsed during a store MEM wait: dmem_wr_o drops the same cycle; the next cycle is FETCH with flags clear.
